// File: rtl/ddr2_write_arbiter.sv
// Round-robin arbiter sharing the DDR2 address and write-data FIFOs between two
// write masters; each 2-beat burst is kept atomic and the non-owner sees full.
//   IDLE  | no burst in progress, DDR outputs idle, both masters stalled
//   BEAT1 | owner granted, waiting to push address + first data beat
//   BEAT2 | address accepted, waiting to push second data beat
module ddr2_write_arbiter #(
    parameter int ADDR_W = 31,
    parameter int DATA_W = 128,
    parameter int MASK_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] m0_af_addr_din,
    input  logic              m0_af_wr_en,
    input  logic [DATA_W-1:0] m0_wdf_din,
    input  logic [MASK_W-1:0] m0_wdf_mask_din,
    input  logic              m0_wdf_wr_en,
    output logic              m0_af_full,
    output logic              m0_wdf_full,
    input  logic [ADDR_W-1:0] m1_af_addr_din,
    input  logic              m1_af_wr_en,
    input  logic [DATA_W-1:0] m1_wdf_din,
    input  logic [MASK_W-1:0] m1_wdf_mask_din,
    input  logic              m1_wdf_wr_en,
    output logic              m1_af_full,
    output logic              m1_wdf_full,
    input  logic              af_full,
    input  logic              wdf_full,
    output logic [ADDR_W-1:0] af_addr_din,
    output logic              af_wr_en,
    output logic [DATA_W-1:0] wdf_din,
    output logic [MASK_W-1:0] wdf_mask_din,
    output logic              wdf_wr_en,
    output logic              owner,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT1 = 2'd1,
        BEAT2 = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   owner_q, owner_d;
    logic   rr_last_q, rr_last_d;

    logic   own_af;
    logic   own_wdf;
    logic   beat1_go;
    logic   beat2_go;

    always_comb begin
        own_af   = owner_q ? m1_af_wr_en  : m0_af_wr_en;
        own_wdf  = owner_q ? m1_wdf_wr_en : m0_wdf_wr_en;
        beat1_go = own_af & own_wdf & ~af_full & ~wdf_full;
        beat2_go = own_wdf & ~af_full & ~wdf_full;
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        case (state_q)
            IDLE: begin
                if (m0_af_wr_en && m1_af_wr_en) begin
                    owner_d = ~rr_last_q;
                    state_d = BEAT1;
                end else if (m0_af_wr_en) begin
                    owner_d = 1'b0;
                    state_d = BEAT1;
                end else if (m1_af_wr_en) begin
                    owner_d = 1'b1;
                    state_d = BEAT1;
                end
            end
            BEAT1: begin
                if (beat1_go) begin
                    state_d = BEAT2;
                end
            end
            BEAT2: begin
                if (beat2_go) begin
                    rr_last_d = owner_q;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            rr_last_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
        end
    end

    // Datapath follows the registered owner so muxing never waits on arbitration.
    always_comb begin
        af_addr_din  = '0;
        wdf_din      = '0;
        wdf_mask_din = '1;
        af_wr_en     = 1'b0;
        wdf_wr_en    = 1'b0;
        m0_af_full   = 1'b1;
        m0_wdf_full  = 1'b1;
        m1_af_full   = 1'b1;
        m1_wdf_full  = 1'b1;
        if (state_q != IDLE) begin
            af_addr_din  = owner_q ? m1_af_addr_din  : m0_af_addr_din;
            wdf_din      = owner_q ? m1_wdf_din      : m0_wdf_din;
            wdf_mask_din = owner_q ? m1_wdf_mask_din : m0_wdf_mask_din;
            if (owner_q) begin
                m1_af_full  = af_full;
                m1_wdf_full = wdf_full;
            end else begin
                m0_af_full  = af_full;
                m0_wdf_full = wdf_full;
            end
            af_wr_en  = (state_q == BEAT1) & beat1_go;
            wdf_wr_en = (state_q == BEAT1) ? beat1_go : beat2_go;
        end
    end

    assign owner = owner_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_ddr2_write_arbiter.sv
// Bench for ddr2_write_arbiter: burst-level reference model checked every cycle,
// plus directed scenarios with hand-computed write logs and timing.
module tb_ddr2_write_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [30:0]  m0_af_addr_din = '0, m1_af_addr_din = '0;
    logic         m0_af_wr_en = 1'b0, m1_af_wr_en = 1'b0;
    logic [127:0] m0_wdf_din = '0, m1_wdf_din = '0;
    logic [15:0]  m0_wdf_mask_din = '0, m1_wdf_mask_din = '0;
    logic         m0_wdf_wr_en = 1'b0, m1_wdf_wr_en = 1'b0;
    logic         m0_af_full, m0_wdf_full, m1_af_full, m1_wdf_full;
    logic         af_full = 1'b0, wdf_full = 1'b0;
    logic [30:0]  af_addr_din;
    logic         af_wr_en;
    logic [127:0] wdf_din;
    logic [15:0]  wdf_mask_din;
    logic         wdf_wr_en;
    logic         owner, busy;

    ddr2_write_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_af_addr_din(m0_af_addr_din), .m0_af_wr_en(m0_af_wr_en),
        .m0_wdf_din(m0_wdf_din), .m0_wdf_mask_din(m0_wdf_mask_din),
        .m0_wdf_wr_en(m0_wdf_wr_en), .m0_af_full(m0_af_full), .m0_wdf_full(m0_wdf_full),
        .m1_af_addr_din(m1_af_addr_din), .m1_af_wr_en(m1_af_wr_en),
        .m1_wdf_din(m1_wdf_din), .m1_wdf_mask_din(m1_wdf_mask_din),
        .m1_wdf_wr_en(m1_wdf_wr_en), .m1_af_full(m1_af_full), .m1_wdf_full(m1_wdf_full),
        .af_full(af_full), .wdf_full(wdf_full),
        .af_addr_din(af_addr_din), .af_wr_en(af_wr_en),
        .wdf_din(wdf_din), .wdf_mask_din(wdf_mask_din), .wdf_wr_en(wdf_wr_en),
        .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // Burst-level model: is a burst open, which beat is pending, who owns it,
    // and who finished the last complete burst.
    bit mdl_busy = 0, mdl_second = 0, mdl_owner = 0, mdl_last = 1;
    bit nx_busy  = 0, nx_second  = 0, nx_owner  = 0, nx_last  = 1;

    logic [30:0]  af_log_addr[$];
    bit           af_log_own[$];
    int           af_log_cyc[$];
    logic [127:0] wdf_log[$];
    int           wdf_log_cyc[$];

    always @(posedge clk) begin
        cyc        <= cyc + 1;
        mdl_busy   <= nx_busy;
        mdl_second <= nx_second;
        mdl_owner  <= nx_owner;
        mdl_last   <= nx_last;
    end

    always @(negedge clk) begin : cmp
        logic         o_af, o_wdf, take, e_af_en, e_wdf_en;
        logic [30:0]  e_addr;
        logic [127:0] e_data;
        logic [15:0]  e_mask;
        logic [3:0]   e_full;
        o_af   = mdl_owner ? m1_af_wr_en  : m0_af_wr_en;
        o_wdf  = mdl_owner ? m1_wdf_wr_en : m0_wdf_wr_en;
        take   = mdl_busy && o_wdf && !af_full && !wdf_full && (mdl_second || o_af);
        e_af_en = 1'b0; e_wdf_en = 1'b0; e_addr = '0; e_data = '0; e_mask = '1;
        e_full = 4'b1111;
        if (mdl_busy) begin
            e_addr   = mdl_owner ? m1_af_addr_din  : m0_af_addr_din;
            e_data   = mdl_owner ? m1_wdf_din      : m0_wdf_din;
            e_mask   = mdl_owner ? m1_wdf_mask_din : m0_wdf_mask_din;
            e_full   = mdl_owner ? {2'b11, af_full, wdf_full} : {af_full, wdf_full, 2'b11};
            e_af_en  = take && !mdl_second;
            e_wdf_en = take;
        end
        check("af_wr_en", 128'(af_wr_en), 128'(e_af_en));
        check("wdf_wr_en", 128'(wdf_wr_en), 128'(e_wdf_en));
        check("af_addr_din", 128'(af_addr_din), 128'(e_addr));
        check("wdf_din", wdf_din, e_data);
        check("wdf_mask_din", 128'(wdf_mask_din), 128'(e_mask));
        check("fulls_m0af_m0wdf_m1af_m1wdf",
              128'({m0_af_full, m0_wdf_full, m1_af_full, m1_wdf_full}), 128'(e_full));
        check("owner", 128'(owner), 128'(mdl_owner));
        check("busy", 128'(busy), 128'(mdl_busy));
        if (af_wr_en === 1'b1) begin
            af_log_addr.push_back(af_addr_din);
            af_log_own.push_back(owner);
            af_log_cyc.push_back(cyc);
        end
        if (wdf_wr_en === 1'b1) begin
            wdf_log.push_back(wdf_din);
            wdf_log_cyc.push_back(cyc);
        end
        nx_busy = mdl_busy; nx_second = mdl_second; nx_owner = mdl_owner; nx_last = mdl_last;
        if (rst) begin
            nx_busy = 0; nx_second = 0; nx_owner = 0; nx_last = 1;
        end else if (!mdl_busy) begin
            if (m0_af_wr_en || m1_af_wr_en) begin
                nx_busy   = 1;
                nx_second = 0;
                nx_owner  = (m0_af_wr_en && m1_af_wr_en) ? !mdl_last : m1_af_wr_en;
            end
        end else if (take) begin
            if (!mdl_second) begin
                nx_second = 1;
            end else begin
                nx_busy   = 0;
                nx_second = 0;
                nx_last   = mdl_owner;
            end
        end
    end

    task automatic drive(input bit p, input logic af_en, input logic wdf_en,
                         input logic [30:0] a, input logic [127:0] d);
        if (p) begin
            m1_af_wr_en = af_en; m1_wdf_wr_en = wdf_en; m1_af_addr_din = a;
            m1_wdf_din = d; m1_wdf_mask_din = 16'h0f0f;
        end else begin
            m0_af_wr_en = af_en; m0_wdf_wr_en = wdf_en; m0_af_addr_din = a;
            m0_wdf_din = d; m0_wdf_mask_din = 16'h0000;
        end
    endtask

    task automatic burst(input bit p, input logic [30:0] a, input logic [127:0] d0,
                         input logic [127:0] d1);
        int n;
        drive(p, 1'b1, 1'b1, a, d0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((p ? m1_af_full : m0_af_full) || (p ? m1_wdf_full : m0_wdf_full)) && n < 60);
        if (n >= 60) begin
            timeout("burst_beat1");
            drive(p, 1'b0, 1'b0, '0, '0);
            return;
        end
        @(posedge clk); #1;
        drive(p, 1'b0, 1'b1, a, d1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((p ? m1_af_full : m0_af_full) || (p ? m1_wdf_full : m0_wdf_full)) && n < 60);
        if (n >= 60) timeout("burst_beat2");
        @(posedge clk); #1;
        drive(p, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin : main
        int ab, wb, n, drop_cyc;
        bit own_exp[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [30:0] addr_exp[4] = '{31'h200, 31'h300, 31'h202, 31'h302};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_owner", 128'(owner), 128'(0));
        check("rst_mask", 128'(wdf_mask_din), 128'(16'hffff));
        check("rst_m0_af_full", 128'(m0_af_full), 128'(1));
        check("rst_m1_wdf_full", 128'(m1_wdf_full), 128'(1));
        @(posedge clk); #1;

        // Simultaneous requests right after reset: order 0,1,0,1
        ab = af_log_own.size();
        fork
            begin burst(0, 31'h200, 128'ha200, 128'hb200); burst(0, 31'h202, 128'ha202, 128'hb202); end
            begin burst(1, 31'h300, 128'ha300, 128'hb300); burst(1, 31'h302, 128'ha302, 128'hb302); end
        join
        repeat (2) @(posedge clk); #1;
        check("rr_af_count", 128'(af_log_own.size() - ab), 128'(4));
        for (int i = 0; i < 4; i++) begin
            if (ab + i < af_log_own.size()) begin
                check("rr_order", 128'(af_log_own[ab+i]), 128'(own_exp[i]));
                check("rr_addr", 128'(af_log_addr[ab+i]), 128'(addr_exp[i]));
            end
        end

        // Single master burst, FIFOs empty
        ab = af_log_addr.size(); wb = wdf_log.size();
        burst(0, 31'h100, 128'hd1a, 128'hd1b);
        repeat (2) @(posedge clk); #1;
        check("single_af_count", 128'(af_log_addr.size() - ab), 128'(1));
        check("single_wdf_count", 128'(wdf_log.size() - wb), 128'(2));
        if (af_log_addr.size() > ab) check("single_addr", 128'(af_log_addr[ab]), 128'(31'h100));
        if (wdf_log.size() >= wb + 2) begin
            check("single_beat1", wdf_log[wb], 128'hd1a);
            check("single_beat2", wdf_log[wb+1], 128'hd1b);
            check("single_gap", 128'(wdf_log_cyc[wb+1] - wdf_log_cyc[wb]), 128'(1));
        end

        // wdf_full for 3 cycles during BEAT2
        ab = af_log_addr.size(); wb = wdf_log.size();
        fork
            burst(0, 31'h400, 128'hd4a, 128'hd4b);
            begin
                n = 0;
                do begin @(negedge clk); n++; end while (af_wr_en !== 1'b1 && n < 40);
                if (n >= 40) timeout("wdf_full_wait");
                @(posedge clk); #1 wdf_full = 1'b1;
                repeat (3) @(posedge clk);
                #1 wdf_full = 1'b0;
            end
        join
        repeat (2) @(posedge clk); #1;
        check("wdffull_af_count", 128'(af_log_addr.size() - ab), 128'(1));
        check("wdffull_wdf_count", 128'(wdf_log.size() - wb), 128'(2));
        if (wdf_log.size() >= wb + 2) begin
            check("wdffull_gap", 128'(wdf_log_cyc[wb+1] - wdf_log_cyc[wb]), 128'(4));
            check("wdffull_beat2", wdf_log[wb+1], 128'hd4b);
        end

        // af_full held in BEAT1
        ab = af_log_addr.size(); wb = wdf_log.size();
        af_full  = 1'b1;
        drop_cyc = -1;
        fork
            burst(0, 31'h500, 128'hd5a, 128'hd5b);
            begin
                n = 0;
                do begin @(negedge clk); n++; end while (busy !== 1'b1 && n < 40);
                if (n >= 40) timeout("af_full_wait");
                check("affull_m0_sees_full", 128'(m0_af_full), 128'(1));
                check("affull_no_af_write", 128'(af_wr_en), 128'(0));
                check("affull_no_wdf_write", 128'(wdf_wr_en), 128'(0));
                repeat (2) @(posedge clk);
                #1 af_full = 1'b0;
                drop_cyc = cyc;
            end
        join
        repeat (2) @(posedge clk); #1;
        check("affull_af_count", 128'(af_log_addr.size() - ab), 128'(1));
        check("affull_wdf_count", 128'(wdf_log.size() - wb), 128'(2));
        if (af_log_cyc.size() > ab) check("affull_accept_cycle", 128'(af_log_cyc[ab]), 128'(drop_cyc));

        // Reset while stalled in BEAT2 (last completed burst was m0)
        drive(0, 1'b1, 1'b1, 31'h600, 128'hd6a);
        n = 0;
        do begin @(negedge clk); n++; end while ((m0_af_full || m0_wdf_full) && n < 40);
        if (n >= 40) timeout("rst_beat1_wait");
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, '0, '0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_in_beat2", 128'(busy), 128'(1));
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_busy", 128'(busy), 128'(0));
        check("rst_mid_owner", 128'(owner), 128'(0));
        check("rst_mid_addr", 128'(af_addr_din), 128'(0));
        check("rst_mid_data", wdf_din, 128'(0));
        check("rst_mid_mask", 128'(wdf_mask_din), 128'(16'hffff));
        check("rst_mid_m0_full", 128'(m0_af_full), 128'(1));
        @(posedge clk); #1;
        ab = af_log_own.size();
        fork
            burst(0, 31'h700, 128'hd7a, 128'hd7b);
            burst(1, 31'h710, 128'hd7c, 128'hd7d);
        join
        repeat (2) @(posedge clk); #1;
        check("rst_rr_count", 128'(af_log_own.size() - ab), 128'(2));
        if (af_log_own.size() >= ab + 2) begin
            check("rst_rr_first_m0", 128'(af_log_own[ab]), 128'(0));
            check("rst_rr_second_m1", 128'(af_log_own[ab+1]), 128'(1));
        end

        // m1 pushes data while m0 owns the FIFOs
        ab = af_log_addr.size(); wb = wdf_log.size();
        fork
            burst(0, 31'h800, 128'hd8a, 128'hd8b);
            begin
                m1_wdf_wr_en = 1'b1; m1_wdf_din = 128'hbad; m1_wdf_mask_din = 16'h1234;
                repeat (8) @(posedge clk);
                #1 m1_wdf_wr_en = 1'b0;
            end
        join
        repeat (3) @(posedge clk); #1;
        check("nonowner_af_count", 128'(af_log_addr.size() - ab), 128'(1));
        check("nonowner_ratio", 128'(wdf_log.size() - wb), 128'(2 * (af_log_addr.size() - ab)));
        if (wdf_log.size() >= wb + 2) begin
            check("nonowner_beat1", wdf_log[wb], 128'hd8a);
            check("nonowner_beat2", wdf_log[wb+1], 128'hd8b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
